// File: rtl/kalman_update_seq_if.sv
// Bundle of the sample strobe, gain operands, divider AXIS channels and status
// outputs of the Kalman update sequencer; master is the sequencer side.
interface kalman_update_seq_if #(
    parameter int DIV_WIDTH = 32
);
    logic                 s_valid;
    logic [DIV_WIDTH-1:0] num_in;
    logic [DIV_WIDTH-1:0] den_in;
    logic [DIV_WIDTH-1:0] div_dividend_tdata;
    logic                 div_dividend_tvalid;
    logic                 div_dividend_tready;
    logic [DIV_WIDTH-1:0] div_divisor_tdata;
    logic                 div_divisor_tvalid;
    logic                 div_divisor_tready;
    logic [DIV_WIDTH-1:0] div_dout_tdata;
    logic                 div_dout_tvalid;
    logic [DIV_WIDTH-1:0] k_gain;
    logic                 upd_en;
    logic                 busy;
    logic [15:0]          drop_cnt;
    logic                 err_timeout;
    logic                 err_div0;

    modport master (
        input  s_valid, num_in, den_in,
        input  div_dividend_tready, div_divisor_tready,
        input  div_dout_tdata, div_dout_tvalid,
        output div_dividend_tdata, div_dividend_tvalid,
        output div_divisor_tdata, div_divisor_tvalid,
        output k_gain, upd_en, busy, drop_cnt, err_timeout, err_div0
    );

    modport slave (
        output s_valid, num_in, den_in,
        output div_dividend_tready, div_divisor_tready,
        output div_dout_tdata, div_dout_tvalid,
        input  div_dividend_tdata, div_dividend_tvalid,
        input  div_divisor_tdata, div_divisor_tvalid,
        input  k_gain, upd_en, busy, drop_cnt, err_timeout, err_div0
    );
endinterface

// File: rtl/kalman_update_seq.sv
// Decimates the ADC stream into update ticks and, per tick, runs one gain
// division through an external AXIS divider before pulsing upd_en.
module kalman_update_seq #(
    parameter int DECIM     = 1024,
    parameter int DIV_WIDTH = 32,
    parameter int TIMEOUT   = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    kalman_update_seq_if.master  bus
);
    localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, APPLY} state_t;

    state_t               state;
    logic [CW-1:0]        samp_cnt;
    logic [TW-1:0]        wait_cnt;
    logic                 tick;
    logic                 dvd_pend, dvs_pend;
    logic                 dvd_valid, dvs_valid;
    logic                 dvd_fire, dvs_fire;
    logic                 dvd_done, dvs_done;
    logic [DIV_WIDTH-1:0] dvd_data, dvs_data;
    logic [DIV_WIDTH-1:0] k_gain;
    logic                 upd_en;
    logic [15:0]          drop_cnt;
    logic                 err_timeout, err_div0;

    assign tick     = bus.s_valid && (samp_cnt == CW'(DECIM - 1));
    assign dvd_fire = dvd_valid && bus.div_dividend_tready;
    assign dvs_fire = dvs_valid && bus.div_divisor_tready;
    // A channel is finished once its pending request has been accepted
    assign dvd_done = !dvd_pend || dvd_fire;
    assign dvs_done = !dvs_pend || dvs_fire;

    always_ff @(posedge clk) begin
        if (rst) begin
            samp_cnt <= '0;
        end else if (bus.s_valid) begin
            if (samp_cnt == CW'(DECIM - 1))
                samp_cnt <= '0;
            else
                samp_cnt <= samp_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            dvd_pend    <= 1'b0;
            dvs_pend    <= 1'b0;
            dvd_valid   <= 1'b0;
            dvs_valid   <= 1'b0;
            dvd_data    <= '0;
            dvs_data    <= '0;
            k_gain      <= '0;
            upd_en      <= 1'b0;
            drop_cnt    <= '0;
            err_timeout <= 1'b0;
            err_div0    <= 1'b0;
        end else begin
            if (tick && state != IDLE && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
            case (state)
                IDLE: begin
                    if (tick) begin
                        dvd_data <= bus.num_in;
                        dvs_data <= bus.den_in;
                        if (bus.den_in == '0) begin
                            err_div0 <= 1'b1;
                        end else begin
                            dvd_pend <= 1'b1;
                            dvs_pend <= 1'b1;
                            state    <= ISSUE;
                        end
                    end
                end
                // Valids rise one cycle after entry and each channel retires on its own
                ISSUE: begin
                    if (dvd_fire) begin
                        dvd_valid <= 1'b0;
                        dvd_pend  <= 1'b0;
                    end else if (dvd_pend) begin
                        dvd_valid <= 1'b1;
                    end
                    if (dvs_fire) begin
                        dvs_valid <= 1'b0;
                        dvs_pend  <= 1'b0;
                    end else if (dvs_pend) begin
                        dvs_valid <= 1'b1;
                    end
                    if (dvd_done && dvs_done) begin
                        wait_cnt <= '0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.div_dout_tvalid) begin
                        k_gain <= bus.div_dout_tdata;
                        upd_en <= 1'b1;
                        state  <= APPLY;
                    end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                        err_timeout <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                APPLY: begin
                    upd_en <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.div_dividend_tdata  = dvd_data;
    assign bus.div_dividend_tvalid = dvd_valid;
    assign bus.div_divisor_tdata   = dvs_data;
    assign bus.div_divisor_tvalid  = dvs_valid;
    assign bus.k_gain              = k_gain;
    assign bus.upd_en              = upd_en;
    assign bus.busy                = (state != IDLE);
    assign bus.drop_cnt            = drop_cnt;
    assign bus.err_timeout         = err_timeout;
    assign bus.err_div0            = err_div0;
endmodule

// File: tb/tb_kalman_update_seq.sv
// Bench for kalman_update_seq: each accepted tick becomes a timeline of cycle
// stamps (valid windows, wait start, apply cycle) that every output is checked against.
module tb_kalman_update_seq;
    localparam int DECIM = 4;
    localparam int DW    = 32;
    localparam int TO    = 64;
    localparam int NEVER = 100000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    kalman_update_seq_if #(.DIV_WIDTH(DW)) bus ();

    kalman_update_seq #(.DECIM(DECIM), .DIV_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int n = 0;
    bit rst_prev;

    // Reference timeline of the transaction in flight plus accumulated state
    bit          t_on;
    int          tk, tdd, tds, tdl;
    logic [31:0] t_num, t_den, t_dout;
    logic [31:0] kg_exp;
    int          drop_exp, samp;
    bit          err_t_exp, err_d_exp, drop_pend, div0_pend;

    int          f_dd = -1, f_ds = -1, f_dl = -1;
    bit          f_dout_on;
    logic [31:0] f_dout;

    int upd_seen, dvd_cyc, dvs_cyc, upd_n, tick_n;

    function automatic int waitStart();
        return tk + 3 + ((tdd > tds) ? tdd : tds);
    endfunction

    function automatic int lastBusy();
        return (tdl < TO) ? waitStart() + tdl + 1 : waitStart() + TO - 1;
    endfunction

    function automatic bit busyAt(input int c);
        return t_on && c >= tk + 1 && c <= lastBusy();
    endfunction

    task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, n, act, exp);
        end
    endtask

    task automatic advanceModel();
        n++;
        if (rst_prev) begin
            t_on = 0; kg_exp = '0; drop_exp = 0; err_t_exp = 0; err_d_exp = 0;
            samp = 0; drop_pend = 0; div0_pend = 0;
        end else begin
            if (drop_pend && drop_exp < 65535) drop_exp++;
            if (div0_pend) err_d_exp = 1;
            drop_pend = 0;
            div0_pend = 0;
            if (t_on) begin
                if (tdl < TO && n == waitStart() + tdl + 1) kg_exp = t_dout;
                if (n == lastBusy() + 1) begin
                    if (tdl >= TO) err_t_exp = 1;
                    t_on = 0;
                end
            end
        end
    endtask

    task automatic checkOutput();
        bit dvd_e, dvs_e, upd_e;
        dvd_e = t_on && n >= tk + 2 && n <= tk + 2 + tdd;
        dvs_e = t_on && n >= tk + 2 && n <= tk + 2 + tds;
        upd_e = t_on && tdl < TO && n == waitStart() + tdl + 1;
        checkEq("busy", 32'(bus.busy), 32'(busyAt(n)));
        checkEq("dvd_tvalid", 32'(bus.div_dividend_tvalid), 32'(dvd_e));
        checkEq("dvs_tvalid", 32'(bus.div_divisor_tvalid), 32'(dvs_e));
        if (dvd_e) checkEq("dvd_tdata", bus.div_dividend_tdata, t_num);
        if (dvs_e) checkEq("dvs_tdata", bus.div_divisor_tdata, t_den);
        checkEq("upd_en", 32'(bus.upd_en), 32'(upd_e));
        checkEq("k_gain", bus.k_gain, kg_exp);
        checkEq("drop_cnt", 32'(bus.drop_cnt), 32'(drop_exp));
        checkEq("err_timeout", 32'(bus.err_timeout), 32'(err_t_exp));
        checkEq("err_div0", 32'(bus.err_div0), 32'(err_d_exp));
        if (bus.upd_en) begin upd_seen++; upd_n = n; end
        if (bus.div_dividend_tvalid) dvd_cyc++;
        if (bus.div_divisor_tvalid) dvs_cyc++;
    endtask

    task automatic applyStimulus(input bit sv, input logic [31:0] nm, input logic [31:0] dn, input bit r);
        int w;
        rst = r;
        rst_prev = r;
        bus.s_valid = sv;
        bus.num_in = nm;
        bus.den_in = dn;
        if (!r && sv) begin
            if (samp == DECIM - 1) begin
                if (busyAt(n)) begin
                    drop_pend = 1;
                end else if (dn == '0) begin
                    div0_pend = 1;
                end else begin
                    t_on = 1; tk = n; tick_n = n;
                    tdd = (f_dd >= 0) ? f_dd : int'($urandom_range(0, 4));
                    tds = (f_ds >= 0) ? f_ds : int'($urandom_range(0, 4));
                    if (f_dl >= 0) tdl = f_dl;
                    else tdl = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, 8));
                    t_num = nm; t_den = dn;
                    t_dout = f_dout_on ? f_dout : $urandom;
                end
                samp = 0;
            end else begin
                samp++;
            end
        end
        // Divider responder: tready held low until the scheduled accept cycle
        if (t_on && n >= tk + 2 && n < tk + 2 + tdd) bus.div_dividend_tready = 1'b0;
        else if (t_on && n == tk + 2 + tdd)         bus.div_dividend_tready = 1'b1;
        else                                          bus.div_dividend_tready = 1'($urandom_range(0, 1));
        if (t_on && n >= tk + 2 && n < tk + 2 + tds) bus.div_divisor_tready = 1'b0;
        else if (t_on && n == tk + 2 + tds)         bus.div_divisor_tready = 1'b1;
        else                                          bus.div_divisor_tready = 1'($urandom_range(0, 1));
        w = waitStart();
        if (t_on && n >= w && n <= lastBusy() && !(tdl < TO && n == lastBusy())) begin
            bus.div_dout_tvalid = (tdl < TO && n == w + tdl);
            bus.div_dout_tdata  = t_dout;
        end else begin
            bus.div_dout_tvalid = ($urandom_range(0, 3) == 0);
            bus.div_dout_tdata  = $urandom;
        end
    endtask

    task automatic cycle(input bit sv, input logic [31:0] nm, input logic [31:0] dn, input bit r);
        @(posedge clk);
        #1;
        advanceModel();
        checkOutput();
        applyStimulus(sv, nm, dn, r);
    endtask

    task automatic idleCycles(input int c);
        for (int i = 0; i < c; i++) cycle(1'b0, $urandom, $urandom, 1'b0);
    endtask

    task automatic clearObs();
        upd_seen = 0; dvd_cyc = 0; dvs_cyc = 0; upd_n = -1;
    endtask

    task automatic setDelays(input int dd, input int ds, input int dl, input logic [31:0] dout);
        f_dd = dd; f_ds = ds; f_dl = dl; f_dout_on = 1; f_dout = dout;
    endtask

    task automatic samples(input int c, input logic [31:0] nm, input logic [31:0] dn);
        for (int i = 0; i < c; i++) cycle(1'b1, nm, dn, 1'b0);
    endtask

    initial begin
        rst = 1'b1; rst_prev = 1'b1;
        bus.s_valid = 1'b0; bus.num_in = '0; bus.den_in = '0;
        bus.div_dividend_tready = 1'b0; bus.div_divisor_tready = 1'b0;
        bus.div_dout_tvalid = 1'b0; bus.div_dout_tdata = '0;
        cycle(1'b0, '0, '0, 1'b1);

        // Immediate divider: single update, latency 4 from the tick cycle
        setDelays(0, 0, 0, 32'h8000_0000);
        clearObs();
        samples(4, 32'h40, 32'h80);
        idleCycles(10);
        checkEq("A upd count", 32'(upd_seen), 32'd1);
        checkEq("A latency", 32'(upd_n - tick_n), 32'd4);
        checkEq("A k_gain", bus.k_gain, 32'h8000_0000);
        checkEq("A drop_cnt", 32'(bus.drop_cnt), 32'd0);

        // Dividend accepted three cycles late, divisor immediately
        cycle(1'b0, '0, '0, 1'b1);
        setDelays(3, 0, 0, 32'h0000_1234);
        clearObs();
        samples(4, 32'h55, 32'h99);
        idleCycles(12);
        checkEq("B dvd cycles", 32'(dvd_cyc), 32'd4);
        checkEq("B dvs cycles", 32'(dvs_cyc), 32'd1);
        checkEq("B k_gain", bus.k_gain, 32'h0000_1234);

        // Quotient never returned: abort after the wait budget, late dout ignored
        setDelays(0, 0, NEVER, 32'hDEAD_BEEF);
        clearObs();
        samples(4, 32'h11, 32'h22);
        idleCycles(80);
        checkEq("C err_timeout", 32'(bus.err_timeout), 32'd1);
        checkEq("C busy", 32'(bus.busy), 32'd0);
        checkEq("C k_gain", bus.k_gain, 32'h0000_1234);
        checkEq("C upd count", 32'(upd_seen), 32'd0);

        // Second tick arrives while the first still waits on the divider
        cycle(1'b0, '0, '0, 1'b1);
        setDelays(0, 0, 20, 32'h0000_0777);
        clearObs();
        samples(8, 32'h31, 32'h62);
        idleCycles(30);
        checkEq("D drop_cnt", 32'(bus.drop_cnt), 32'd1);
        checkEq("D upd count", 32'(upd_seen), 32'd1);

        // Zero denominator at the tick
        cycle(1'b0, '0, '0, 1'b1);
        clearObs();
        samples(4, 32'h10, 32'h0);
        idleCycles(5);
        checkEq("E err_div0", 32'(bus.err_div0), 32'd1);
        checkEq("E tvalid cycles", 32'(dvd_cyc + dvs_cyc), 32'd0);
        checkEq("E upd count", 32'(upd_seen), 32'd0);

        // Reset while issuing, then a clean transaction
        cycle(1'b0, '0, '0, 1'b1);
        setDelays(0, 0, 0, 32'h5A5A_0001);
        clearObs();
        samples(4, 32'h21, 32'h42);
        idleCycles(1);
        cycle(1'b0, '0, '0, 1'b1);
        idleCycles(6);
        checkEq("F upd after rst", 32'(upd_seen), 32'd0);
        samples(4, 32'h23, 32'h46);
        idleCycles(10);
        checkEq("F upd count", 32'(upd_seen), 32'd1);
        checkEq("F k_gain", bus.k_gain, 32'h5A5A_0001);

        // Random traffic, divider timing and occasional resets
        f_dd = -1; f_ds = -1; f_dl = -1; f_dout_on = 0;
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom,
                  ($urandom_range(0, 15) == 0) ? 32'h0 : $urandom,
                  $urandom_range(0, 499) == 0);
        end
        idleCycles(TO + 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/kalman_update_seq.md
KALMAN_UPDATE_SEQ -- requirements
Module: kalman_update_seq

Interface
REQ-001 SHALL have parameter DECIM, default 1024: number of accepted ADC samples per Kalman update.
REQ-002 SHALL have parameter DIV_WIDTH, default 32: width of divider operands and quotient.
REQ-003 SHALL have parameter TIMEOUT, default 64: maximum cycles in WAIT before abort.
REQ-004 SHALL have port clk  in  1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  in  1: synchronous reset, active-high.
REQ-006 SHALL have port s_valid  in  1: ADC sample strobe (AXIS tvalid of the input stream).
REQ-007 SHALL have port num_in  in  DIV_WIDTH: gain numerator from the datapath, phi^2*P+Q.
REQ-008 SHALL have port den_in  in  DIV_WIDTH: gain denominator from the datapath, phi^2*P+Q+R.
REQ-009 SHALL have ports div_dividend_tdata  out  DIV_WIDTH, div_dividend_tvalid  out  1, div_dividend_tready  in  1: divider dividend channel.
REQ-010 SHALL have ports div_divisor_tdata  out  DIV_WIDTH, div_divisor_tvalid  out  1, div_divisor_tready  in  1: divider divisor channel.
REQ-011 SHALL have ports div_dout_tdata  in  DIV_WIDTH, div_dout_tvalid  in  1: divider quotient channel, always accepted.
REQ-012 SHALL have port k_gain  out  DIV_WIDTH: last valid Kalman gain.
REQ-013 SHALL have port upd_en  out  1: one-cycle pulse; datapath applies the update with k_gain.
REQ-014 SHALL have port busy  out  1: high in any state other than IDLE.
REQ-015 SHALL have port drop_cnt  out  16: saturating count of update ticks lost while busy.
REQ-016 SHALL have ports err_timeout  out  1 and err_div0  out  1: sticky error flags.

Function
REQ-017 Sample counter SHALL increment on each s_valid and wrap DECIM-1 -> 0; a tick SHALL be generated on the cycle s_valid is high with counter == DECIM-1.
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT, APPLY.
REQ-019 IDLE + tick: latch num_in/den_in into operand registers on the same edge; go to ISSUE, or stay in IDLE and set err_div0 when den_in == 0 (no divider traffic, no upd_en).
REQ-020 ISSUE: both tvalid SHALL assert the cycle after entry; each channel SHALL hold tvalid and tdata stable until its own tready is sampled high, then deassert independently.
REQ-021 ISSUE -> WAIT SHALL occur on the cycle the second of the two channels completes; simultaneous completion is allowed.
REQ-022 WAIT: first div_dout_tvalid SHALL capture div_dout_tdata into k_gain and move to APPLY.
REQ-023 WAIT timeout counter SHALL start at 0 on entry; on reaching TIMEOUT without dout, set err_timeout, return to IDLE, k_gain unchanged, no upd_en.
REQ-024 APPLY SHALL last exactly one cycle with upd_en = 1, then return to IDLE.
REQ-025 Latency SHALL be tick -> upd_en = 1 (ISSUE entry) + handshake cycles + dout wait + 1; with tready and dout both immediate, upd_en SHALL pulse 4 cycles after the tick edge.
REQ-026 A tick in any state other than IDLE SHALL increment drop_cnt, saturating at 16'hFFFF, and SHALL NOT restart the sequence.
REQ-027 div_dout_tvalid outside WAIT SHALL be ignored; k_gain SHALL NOT change.
REQ-028 The sample counter SHALL keep counting independently of the FSM state.
REQ-029 err_timeout and err_div0 SHALL clear only on rst.

Reset
REQ-030 rst SHALL force the state to IDLE and clear the sample counter, timeout counter, drop_cnt, both tvalid outputs, upd_en, err_timeout, err_div0 and k_gain to 0.
REQ-031 rst asserted mid-transaction SHALL abandon it: tvalids low next cycle, no upd_en, and any later dout ignored.

Verification
REQ-032 DECIM=4; tready=1; dout one cycle after handshake; 4 s_valid; num=0x40, den=0x80, dout=0x80000000 -> one upd_en pulse, k_gain=0x80000000, drop_cnt=0.
REQ-033 dividend tready delayed 3 cycles, divisor tready immediate -> divisor tvalid drops after 1 cycle; dividend tdata held stable until accepted; WAIT entered only after dividend accepted.
REQ-034 dout never returned, TIMEOUT=64 -> err_timeout=1 after 64 WAIT cycles, FSM IDLE, k_gain unchanged; late dout ignored.
REQ-035 Two ticks 4 samples apart while WAIT stalls -> drop_cnt=1; exactly one upd_en for the first tick.
REQ-036 den_in=0 at tick -> err_div0=1, no tvalid asserted, no upd_en.
REQ-037 rst pulsed while in ISSUE -> all outputs at reset values next cycle; following tick runs a clean transaction.
